// File: rtl/gpr_file.sv
// gpr_file: dual-issue register file with bypassed reads and a per-register
// pending-write scoreboard sitting between writeback and dispatch.
module gpr_file #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_NUM     = 32,
  localparam int unsigned AW         = $clog2(REG_NUM)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic [ISSUE_WIDTH-1:0]            i_wb_we,
  input  logic [ISSUE_WIDTH*AW-1:0]         i_wb_waddr,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0] i_wb_wdata,
  input  logic [2*ISSUE_WIDTH*AW-1:0]       i_rd_addr,
  output logic [2*ISSUE_WIDTH*DATA_WIDTH-1:0] o_rd_data,
  output logic [2*ISSUE_WIDTH-1:0]          o_rd_busy,
  input  logic [ISSUE_WIDTH-1:0]            i_issue_we,
  input  logic [ISSUE_WIDTH*AW-1:0]         i_issue_waddr,
  output logic [ISSUE_WIDTH-1:0]            o_issue_full
);

  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
  logic [1:0]            r_cnt  [REG_NUM];

  logic [AW-1:0]         w_wb_waddr    [ISSUE_WIDTH];
  logic [DATA_WIDTH-1:0] w_wb_wdata    [ISSUE_WIDTH];
  logic [AW-1:0]         w_issue_waddr [ISSUE_WIDTH];
  logic [AW-1:0]         w_rd_addr     [2*ISSUE_WIDTH];
  logic [DATA_WIDTH-1:0] w_rd_data     [2*ISSUE_WIDTH];

  // inc/dec hold 0..ISSUE_WIDTH; sum holds cnt + inc (at most 5)
  logic [2:0] w_inc   [REG_NUM];
  logic [2:0] w_dec   [REG_NUM];
  logic [2:0] w_sum   [REG_NUM];
  logic [1:0] w_cnt_d [REG_NUM];

  // Unpack flattened lane buses into per-lane views
  always_comb begin
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      w_wb_waddr[l]    = i_wb_waddr[l*AW +: AW];
      w_wb_wdata[l]    = i_wb_wdata[l*DATA_WIDTH +: DATA_WIDTH];
      w_issue_waddr[l] = i_issue_waddr[l*AW +: AW];
    end
    for (int p = 0; p < 2*ISSUE_WIDTH; p++) begin
      w_rd_addr[p] = i_rd_addr[p*AW +: AW];
    end
  end

  // Per-register count of lanes issuing to it and lanes writing it back this cycle
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_inc[r] = '0;
      w_dec[r] = '0;
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (i_issue_we[l] && (w_issue_waddr[l] == AW'(r))) w_inc[r] = w_inc[r] + 3'd1;
        if (i_wb_we[l] && (w_wb_waddr[l] == AW'(r)))       w_dec[r] = w_dec[r] + 3'd1;
      end
    end
  end

  // Next pending count: flush wins, r0 pinned at 0, underflow clamps to 0
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      w_sum[r] = {1'b0, r_cnt[r]} + w_inc[r];
      if (i_flush || (r == 0)) begin
        w_cnt_d[r] = '0;
      end else if (w_sum[r] <= w_dec[r]) begin
        w_cnt_d[r] = '0;
      end else if ((w_sum[r] - w_dec[r]) > 3'd3) begin
        w_cnt_d[r] = 2'd3;
      end else begin
        w_cnt_d[r] = 2'(w_sum[r] - w_dec[r]);
      end
    end
  end

  // Scoreboard state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) r_cnt[r] <= w_cnt_d[r];
    end
  end

  // Register storage; later lanes overwrite earlier ones so lane 1 wins on a tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < REG_NUM; r++) r_regs[r] <= '0;
    end else begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (i_wb_we[l] && (w_wb_waddr[l] != '0)) r_regs[w_wb_waddr[l]] <= w_wb_wdata[l];
      end
    end
  end

  // Bypassed reads (younger lane last so it takes priority) and busy flags
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int p = 0; p < 2*ISSUE_WIDTH; p++) begin
      w_rd_data[p] = r_regs[w_rd_addr[p]];
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (i_wb_we[l] && (w_wb_waddr[l] == w_rd_addr[p])) w_rd_data[p] = w_wb_wdata[l];
      end
      if (i_rst || (w_rd_addr[p] == '0)) w_rd_data[p] = '0;
      o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[p];
      // Busy only if something older than this cycle's writebacks is still pending
      o_rd_busy[p] = !i_rst && ({1'b0, r_cnt[w_rd_addr[p]]} > w_dec[w_rd_addr[p]]);
    end
  end

  // Full is independent of issue_we so dispatch can use it to gate issue
  always_comb begin
    o_issue_full = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      o_issue_full[l] = !i_rst && (w_issue_waddr[l] != '0) &&
                        (r_cnt[w_issue_waddr[l]] == 2'd3);
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// Testbench for gpr_file: reset sequences by hand, then a table of per-cycle
// vectors whose expected outputs were worked out by hand.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  wb_we;
  logic [9:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_busy;
  logic [1:0]  issue_we;
  logic [9:0]  issue_waddr;
  logic [1:0]  issue_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_file dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_wb_we      (wb_we),
    .i_wb_waddr   (wb_waddr),
    .i_wb_wdata   (wb_wdata),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_issue_we   (issue_we),
    .i_issue_waddr(issue_waddr),
    .o_issue_full (issue_full)
  );

  typedef struct {
    string       name;
    logic        fl;
    logic [1:0]  wbwe;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  iwe;
    logic [4:0]  ia0;
    logic [4:0]  ia1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic [1:0]  efull;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic fl, logic [1:0] wbwe, logic [4:0] wa0,
                              logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
                              logic [1:0] iwe, logic [4:0] ia0, logic [4:0] ia1,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                              logic [31:0] ed1, logic eb0, logic eb1, logic [1:0] efull);
    vec_t v;
    v.name = n; v.fl = fl; v.wbwe = wbwe; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1;
    v.wd1 = wd1; v.iwe = iwe; v.ia0 = ia0; v.ia1 = ia1; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.efull = efull;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    issue_we = 0; issue_waddr = 0; rd_addr = 0;
  endtask

  task automatic set_wb0(input logic [4:0] a, input logic [31:0] d);
    wb_we = 2'b01; wb_waddr = {5'd0, a}; wb_wdata = {32'd0, d};
  endtask

  // Dispatch must never issue into a full destination (would overflow the count)
  always @(negedge clk) begin
    if (!rst && ((issue_we & issue_full) != 2'b00)) begin
      errors++;
      $display("FAIL protocol: issue_we %b while issue_full %b", issue_we, issue_full);
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    // Write attempted during reset must be lost and never bypass
    set_wb0(5'd5, 32'hDEAD);
    for (int g = 0; g < 8; g++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'(g*4 + p);
      issue_waddr = {5'(g*4), 5'(g*4 + 1)};
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rst_data_r%0d", g*4 + p), rd_data[p*32 +: 32], 32'd0);
        chk($sformatf("rst_busy_r%0d", g*4 + p), {31'd0, rd_busy[p]}, 32'd0);
      end
      chk("rst_full", {30'd0, issue_full}, 32'd0);
    end
    // Release mid-cycle, write r12, confirm stored
    @(posedge clk); #3;
    rst = 1'b0;
    idle();
    set_wb0(5'd12, 32'hBEEF);
    rd_addr = {15'd0, 5'd12};
    @(posedge clk); #1;
    wb_we = 0;
    #1 chk("r12_stored", rd_data[31:0], 32'hBEEF);
    // Assert reset mid-cycle: clears without an edge; a write across an edge is lost
    #1 rst = 1'b1;
    #1 chk("async_rst_clear", rd_data[31:0], 32'd0);
    set_wb0(5'd12, 32'h9999);
    flush = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    idle();
    rd_addr = {15'd0, 5'd12};
    #1 chk("rst_write_lost", rd_data[31:0], 32'd0);
    // First edge after release accepts a write
    set_wb0(5'd5, 32'h1234);
    rd_addr = {15'd0, 5'd5};
    @(posedge clk); #1;
    wb_we = 0;
    #1 chk("r5_first_write", rd_data[31:0], 32'h1234);
    chk("r5_busy", {31'd0, rd_busy[0]}, 32'd0);
    @(posedge clk); #1;

    vecs.push_back(mk("lane_prio",   0, 2'b11, 7, 'hAAAA, 7, 'h5555, 0, 0, 0, 7, 5, 'h5555, 'h1234, 0, 0, 0));
    vecs.push_back(mk("r7_stored",   0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 'h5555, 0, 0, 0, 0));
    vecs.push_back(mk("r0_write",    0, 2'b01, 0, 'hFFFFFFFF, 0, 0, 2'b01, 0, 0, 0, 7, 0, 'h5555, 0, 0, 0));
    vecs.push_back(mk("r0_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 'h1234, 0, 0, 0));
    vecs.push_back(mk("iss_r3_x2",   0, 0, 0, 0, 0, 0, 2'b11, 3, 3, 3, 7, 0, 'h5555, 0, 0, 0));
    vecs.push_back(mk("r3_cnt2",     0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 1, 1, 0));
    vecs.push_back(mk("wb_r3_11",    0, 2'b01, 3, 'h11, 0, 0, 0, 0, 0, 3, 0, 'h11, 0, 1, 0, 0));
    vecs.push_back(mk("r3_cnt1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 'h11, 'h11, 1, 1, 0));
    vecs.push_back(mk("wb_r3_22",    0, 2'b10, 0, 0, 3, 'h22, 0, 0, 0, 3, 5, 'h22, 'h1234, 0, 0, 0));
    vecs.push_back(mk("r3_free",     0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 'h22, 'h22, 0, 0, 0));
    vecs.push_back(mk("iss_r9_x2",   0, 0, 0, 0, 0, 0, 2'b11, 9, 9, 9, 3, 0, 'h22, 0, 0, 0));
    vecs.push_back(mk("iss_r9_3rd",  0, 0, 0, 0, 0, 0, 2'b01, 9, 9, 9, 9, 0, 0, 1, 1, 0));
    vecs.push_back(mk("r9_full",     0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 0, 0, 0, 1, 0, 2'b11));
    vecs.push_back(mk("wb_r9",       0, 2'b01, 9, 'h99, 0, 0, 0, 9, 3, 9, 9, 'h99, 'h99, 1, 1, 2'b01));
    vecs.push_back(mk("r9_unfull",   0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 9, 'h99, 'h99, 1, 1, 0));
    vecs.push_back(mk("net_zero",    0, 2'b01, 9, 'h98, 0, 0, 2'b01, 9, 0, 9, 9, 'h98, 'h98, 1, 1, 0));
    vecs.push_back(mk("r9_cnt2",     0, 2'b01, 9, 'h97, 0, 0, 0, 0, 0, 9, 0, 'h97, 0, 1, 0, 0));
    vecs.push_back(mk("iss_r4_x2",   0, 0, 0, 0, 0, 0, 2'b11, 4, 4, 4, 9, 0, 'h97, 0, 1, 0));
    vecs.push_back(mk("flush_wb_r4", 1, 2'b01, 4, 'h77, 0, 0, 0, 0, 0, 4, 9, 'h77, 'h97, 1, 1, 0));
    vecs.push_back(mk("after_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 9, 'h77, 'h97, 0, 0, 0));
    vecs.push_back(mk("wb_r4_no_uf", 0, 2'b01, 4, 'h78, 0, 0, 0, 0, 0, 4, 4, 'h78, 'h78, 0, 0, 0));
    vecs.push_back(mk("iss_r4",      0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 4, 4, 'h78, 'h78, 0, 0, 0));
    vecs.push_back(mk("r4_cnt1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 'h78, 'h78, 1, 1, 0));
    vecs.push_back(mk("wb_r4_dual",  0, 2'b11, 4, 'h1, 4, 'h2, 0, 0, 0, 4, 5, 'h2, 'h1234, 0, 0, 0));
    vecs.push_back(mk("r4_clamp",    0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 4, 4, 'h2, 'h2, 0, 0, 0));
    vecs.push_back(mk("r4_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 'h2, 'h2, 1, 1, 0));

    foreach (vecs[i]) begin
      flush       = vecs[i].fl;
      wb_we       = vecs[i].wbwe;
      wb_waddr    = {vecs[i].wa1, vecs[i].wa0};
      wb_wdata    = {vecs[i].wd1, vecs[i].wd0};
      issue_we    = vecs[i].iwe;
      issue_waddr = {vecs[i].ia1, vecs[i].ia0};
      // Ports 2/3 mirror ports 1/0 so every read port is exercised
      rd_addr     = {vecs[i].ra0, vecs[i].ra1, vecs[i].ra1, vecs[i].ra0};
      #3;
      chk({vecs[i].name, "_d0"}, rd_data[31:0],   vecs[i].ed0);
      chk({vecs[i].name, "_d1"}, rd_data[63:32],  vecs[i].ed1);
      chk({vecs[i].name, "_d2"}, rd_data[95:64],  vecs[i].ed1);
      chk({vecs[i].name, "_d3"}, rd_data[127:96], vecs[i].ed0);
      chk({vecs[i].name, "_b0"}, {31'd0, rd_busy[0]}, {31'd0, vecs[i].eb0});
      chk({vecs[i].name, "_b1"}, {31'd0, rd_busy[1]}, {31'd0, vecs[i].eb1});
      chk({vecs[i].name, "_b2"}, {31'd0, rd_busy[2]}, {31'd0, vecs[i].eb1});
      chk({vecs[i].name, "_b3"}, {31'd0, rd_busy[3]}, {31'd0, vecs[i].eb0});
      chk({vecs[i].name, "_full"}, {30'd0, issue_full}, {30'd0, vecs[i].efull});
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
# gpr_file

Dual-issue general-purpose register file with a pending-write scoreboard. It is the consumer end of the writeback stage's register write/forward interface. It sits between writeback and dispatch:

- Writeback drives two write ports (lane 0 older, lane 1 younger).
- Dispatch reads four source operands and is told per operand whether a write is still in flight.
- Dispatch reports newly issued destinations so pending counts track instructions between issue and writeback.

## Interface
Parameters:
- ISSUE_WIDTH, 2, number of issue/writeback lanes (design is verified only at 2)
- DATA_WIDTH, 32, register width
- REG_NUM, 32, architectural registers; address width is log2(REG_NUM) = 5

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush from ctrl; zeroes every pending count
- wb_we[ISSUE_WIDTH]  in  1  writeback lane i writes the register file
- wb_waddr[ISSUE_WIDTH]  in  5  writeback destination
- wb_wdata[ISSUE_WIDTH]  in  32  writeback data
- rd_addr[2*ISSUE_WIDTH]  in  5  source address; entries 2i and 2i+1 belong to lane i
- rd_data[2*ISSUE_WIDTH]  out  32  source value, bypassed
- rd_busy[2*ISSUE_WIDTH]  out  1  source has an older write still outstanding
- issue_we[ISSUE_WIDTH]  in  1  dispatch lane i issues an instruction that writes a register
- issue_waddr[ISSUE_WIDTH]  in  5  destination of that issued instruction
- issue_full[ISSUE_WIDTH]  out  1  lane i destination pending count is 3; dispatch must not issue it this cycle

## Operation
Register file:
- Storage is REG_NUM x DATA_WIDTH. r0 reads 0 always; writes to r0 are ignored.
- Write: each enabled lane writes at the clock edge. If both lanes target the same non-zero address, lane 1's data is stored.
- Read is combinational, with bypass in this priority order:
  - a matching, enabled lane 1 write;
  - else a matching, enabled lane 0 write;
  - else the stored value.
- Addr 0 never bypasses.

Scoreboard:
- Each register has a 2-bit pending count cnt[r]; r0's count is held at 0.
- inc(r) = number of lanes with issue_we && issue_waddr==r (0..2).
- dec(r) = number of lanes with wb_we && wb_waddr==r (0..2).
- Next count: cnt' = cnt + inc − dec.
  - If that result would go below 0, it clamps to 0.
  - Result >3 is a dispatch protocol violation; the bench asserts it never happens.
- Flush: flush has priority over inc/dec, so every cnt' = 0. The register write on that edge still happens.
- rd_busy = (cnt[addr] − dec(addr)) > 0, using the current-cycle dec. A source whose last pending write is landing this cycle therefore reads the bypassed data with busy=0.
- Same-cycle issue of a dependent instruction (in-lane RAW between lanes) is dispatch's responsibility. inc does not affect the current cycle's rd_busy.
- issue_full[i] = cnt[issue_waddr[i]]==3 && issue_waddr[i]!=0. This is combinational and has no dependence on issue_we.

## Timing
Reset:
- While rst is high, all registers and counts are 0.
- rd_data, rd_busy and issue_full are forced to 0, with bypass suppressed.
- Deassertion takes effect without waiting for a clock edge. The first write is accepted at the first rising edge with rst low.

Latency:
- Write to stored value: 1 edge.
- Write to rd_data: 0 cycles, via bypass.
- Issue to rd_busy=1: visible the cycle after the issue edge.
- Writeback to rd_busy=0: same cycle as wb_we.

Boundaries:
- inc and dec on the same register in the same cycle net out.
- Both lanes issuing the same destination: +2.
- Flush mid-reset: reset dominates.
- Reset asserted mid-write: the write is lost.
- All paths are single-cycle. There is no stall input; stalling is the caller's job via issue_we.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Read all 32 registers → 0, rd_busy=0, issue_full=0. Write r5=0x1234 on the first edge after release; next cycle rd_data(r5)=0x1234.
- Lane priority and bypass: write lane0 r7=0xAAAA and lane1 r7=0x5555 in the same cycle. Same cycle, rd_data(r7)=0x5555. After the edge, stored r7=0x5555.
- r0: wb_we lane0 r0=0xFFFF_FFFF and issue r0. Then rd_data(r0)=0, rd_busy=0, count stays 0.
- Scoreboard:
  - Issue r3 on both lanes → cnt=2, rd_busy=1.
  - One wb r3=0x11 → cnt=1, rd_busy still 1.
  - Next wb r3=0x22 → rd_busy=0 that cycle, rd_data=0x22.
- Full: issue r9 three times (cnt=3) → issue_full=1 for a lane targeting r9. One wb r9 → issue_full drops next cycle.
- Flush: with cnt[4]=2, flush plus wb r4=0x77 in the same cycle → next cycle cnt[4]=0, r4=0x77. A subsequent wb r4 leaves cnt at 0 (no underflow).
